// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoded fields and hazard controls toward the stage,
// registered EX operands, stall and bubble statistics back out.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic [4:0]      id_rd;
  logic [7:0]      id_we;
  logic            id_mem_read;
  logic            flush;
  logic            mem_stall;
  logic            id_stall;
  logic            ex_valid;
  logic            ex_mem_read;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [7:0]      ex_we;
  logic [15:0]     bubble_count;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_we, id_mem_read,
           flush, mem_stall,
    input  id_stall, ex_valid, ex_mem_read, ex_pc, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_we, bubble_count
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd, id_we, id_mem_read,
           flush, mem_stall,
    output id_stall, ex_valid, ex_mem_read, ex_pc, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_we, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, flush-under-stall tracking
// and a saturating bubble counter.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic            valid_q, valid_d;
  logic            mem_read_q, mem_read_d;
  logic [7:0]      we_q, we_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [15:0]     bubble_cnt_q, bubble_cnt_d;
  logic            flush_pend_q, flush_pend_d;
  logic            load_use;
  logic            kill;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---- hazard detection (ID side, combinational) ----
  always_comb begin
    load_use = valid_q & mem_read_q & we_q[0] & (rd_q != 5'd0) & bus.id_valid &
               ((rd_q == bus.id_rs1) | (rd_q == bus.id_rs2));
    kill     = bus.flush | flush_pend_q;
  end

  assign bus.id_stall = bus.mem_stall | (load_use & ~kill);

  always_comb begin
    valid_d      = valid_q;
    mem_read_d   = mem_read_q;
    we_d         = we_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    pc_d         = pc_q;
    imm_d        = imm_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_pend_d = flush_pend_q;
    if (bus.mem_stall) begin
      // A flush seen while frozen must still kill the slot once memory releases.
      if (bus.flush) flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = 1'b0;
      if (kill | load_use) begin
        valid_d      = 1'b0;
        mem_read_d   = 1'b0;
        we_d         = 8'd0;
        rs1_d        = 5'd0;
        rs2_d        = 5'd0;
        rd_d         = 5'd0;
        pc_d         = '0;
        imm_d        = '0;
        bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
        valid_d    = bus.id_valid;
        mem_read_d = bus.id_valid & bus.id_mem_read;
        we_d       = bus.id_valid ? bus.id_we : 8'd0;
        rs1_d      = bus.id_rs1;
        rs2_d      = bus.id_rs2;
        rd_d       = bus.id_rd;
        pc_d       = bus.id_pc;
        imm_d      = bus.id_imm;
      end
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      we_q         <= 8'd0;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      pc_q         <= '0;
      imm_q        <= '0;
      bubble_cnt_q <= 16'd0;
      flush_pend_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      we_q         <= we_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_mem_read  = mem_read_q;
  assign bus.ex_we        = we_q;
  assign bus.ex_rs1       = rs1_q;
  assign bus.ex_rs2       = rs2_q;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_pc        = pc_q;
  assign bus.ex_imm       = imm_q;
  assign bus.bubble_count = bubble_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc and immediate fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 id_valid  input  1  decode slot holds a real instruction.
REQ-005 id_pc, id_imm  input  XLEN each  decoded pc and immediate.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  decoded register indices.
REQ-007 id_we  input  8  write-enable vector; bit0 = register-file write.
REQ-008 id_mem_read  input  1  instruction is a load.
REQ-009 flush  input  1  taken branch/jump resolved in EX; kill decode slot.
REQ-010 mem_stall  input  1  data memory busy; freeze pipeline.
REQ-011 ex_valid, ex_mem_read  output  1 each  registered copies for EX.
REQ-012 ex_pc, ex_imm  output  XLEN each; ex_rs1, ex_rs2, ex_rd  output  5 each; ex_we  output  8.
REQ-013 id_stall  output  1  combinational; hold PC and IF/ID register this cycle.
REQ-014 bubble_count  output  16  saturating count of bubbles inserted into EX.

Function
REQ-015 ex_rs1/ex_rs2/ex_rd/ex_we are the operands consumed by the EX-stage ALU forwarding comparison; ex_we bit0 keeps its register-write meaning.
REQ-016 load_use = ex_valid & ex_mem_read & ex_we[0] & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2).
REQ-017 Register x0 never causes a hazard: ex_rd == 0 forces load_use = 0.
REQ-018 Sticky flag flush_pend: set when flush & mem_stall; cleared on first edge with mem_stall = 0.
REQ-019 kill = flush | flush_pend.
REQ-020 Per-edge priority: mem_stall > kill > load_use > advance.
REQ-021 mem_stall = 1: all ex_* registers and bubble_count hold; id_stall = 1.
REQ-022 kill (mem_stall = 0): insert bubble; id_stall = 0 (upstream refetches).
REQ-023 load_use (no stall, no kill): insert bubble; id_stall = 1 same cycle; exactly one bubble per load-use pair.
REQ-024 Advance: ex_* <= id_* fields, ex_valid <= id_valid; if id_valid = 0, ex_we and ex_mem_read load 0.
REQ-025 Bubble: ex_valid, ex_we, ex_mem_read, ex_rs1, ex_rs2, ex_rd, ex_pc, ex_imm all load 0.
REQ-026 bubble_count increments by 1 on each bubble edge (kill or load_use); holds at 16'hFFFF.
REQ-027 id_stall = mem_stall | (load_use & ~kill); no other source.
REQ-028 Latency: id_* to ex_* one cycle when advancing; no combinational path id_* to ex_*.
REQ-029 Simultaneous flush and load_use: flush wins; one bubble, id_stall = 0.
REQ-030 Back-to-back loads to same rd: each dependent consumer gets one bubble; bubble in EX (ex_valid = 0) never triggers load_use.

Reset
REQ-031 rst_n = 0 asynchronously clears all ex_* outputs, flush_pend and bubble_count to 0.
REQ-032 id_stall during reset follows REQ-027 on cleared state (mem_stall passthrough only).
REQ-033 First edge after rst_n deasserts behaves as normal advance.
REQ-034 Reset mid-stall discards flush_pend and frozen contents.

Verification
REQ-035 Load x5 then add rs1 = x5: cycle 2 id_stall = 1, next edge ex_valid = 0, bubble_count = 1; following edge add enters EX.
REQ-036 Load x0 then use x0: no stall, no bubble, bubble_count stays 0.
REQ-037 flush = 1 with mem_stall = 1 for 3 cycles: ex_* frozen 3 cycles, then one bubble on release, flush_pend = 0, bubble_count += 1.
REQ-038 flush and load_use same cycle: id_stall = 0, single bubble, bubble_count += 1.
REQ-039 Preload bubble_count near 16'hFFFF via 70000 forced hazards: saturates at 16'hFFFF, no wrap.
REQ-040 rst_n pulsed low mid-mem_stall: all ex_* = 0 immediately (before clock edge), bubble_count = 0.
